// File: rtl/quarter_sine_phase_folder.sv
// Phase accumulator and quadrant folder that drives a quarter-wave sine ROM
// and restores the sign of the returned magnitude into a full-wave sample.
module quarter_sine_phase_folder #(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample_en,
    input  logic [PHASE_WIDTH-1:0] phase_inc,
    input  logic                   sync,
    input  logic [PHASE_WIDTH-1:0] phase_offset,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  rom_q,
    output logic [DATA_WIDTH:0]    sine_out,
    output logic                   out_valid
);

    logic [PHASE_WIDTH-1:0] acc;
    logic [PHASE_WIDTH-1:0] phase;
    logic [1:0]             quadrant;
    logic [ADDR_WIDTH-1:0]  idx;
    logic [ADDR_WIDTH-1:0]  addr_fold;
    logic [DATA_WIDTH:0]    mag;
    logic                   neg_a, neg_b;
    logic                   valid_a, valid_b;

    // A sync on the same cycle as a strobe makes the offset the lookup phase.
    assign phase     = sync ? phase_offset : acc;
    assign quadrant  = phase[PHASE_WIDTH-1:PHASE_WIDTH-2];
    assign idx       = phase[PHASE_WIDTH-3 -: ADDR_WIDTH];
    // 2^ADDR_WIDTH-1-idx is just the bitwise complement of idx.
    assign addr_fold = quadrant[0] ? ~idx : idx;
    assign mag       = {1'b0, rom_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (sample_en) begin
            acc <= phase + phase_inc;
        end else if (sync) begin
            acc <= phase_offset;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr <= '0;
            neg_a    <= 1'b0;
            valid_a  <= 1'b0;
        end else begin
            valid_a <= sample_en;
            if (sample_en) begin
                rom_addr <= addr_fold;
                neg_a    <= quadrant[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            neg_b   <= 1'b0;
            valid_b <= 1'b0;
        end else begin
            neg_b   <= neg_a;
            valid_b <= valid_a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sine_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= valid_b;
            if (valid_b) begin
                sine_out <= neg_b ? -mag : mag;
            end
        end
    end

endmodule

// File: tb/tb_quarter_sine_phase_folder.sv
// Directed bench for quarter_sine_phase_folder with a 1-cycle registered
// quarter-sine ROM model whose contents are rom[i] = i*64+1.
module tb_quarter_sine_phase_folder;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_en;
    logic [31:0] phase_inc;
    logic        sync;
    logic [31:0] phase_offset;
    logic [8:0]  rom_addr;
    logic [15:0] rom_q;
    logic [16:0] sine_out;
    logic        out_valid;

    int pass_cnt = 0;
    int total_cnt = 0;

    quarter_sine_phase_folder dut (
        .clk          (clk),
        .reset        (reset),
        .sample_en    (sample_en),
        .phase_inc    (phase_inc),
        .sync         (sync),
        .phase_offset (phase_offset),
        .rom_addr     (rom_addr),
        .rom_q        (rom_q),
        .sine_out     (sine_out),
        .out_valid    (out_valid)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        rom_q <= {rom_addr, 6'd0} + 16'd1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single strobe followed by two idle cycles; returns the address seen one
    // cycle after the strobe and the output seen three cycles after it.
    task automatic run_strobe(input logic s, input logic [31:0] off, input logic [31:0] inc,
                              output logic [8:0] a, output logic [16:0] y, output logic v);
        sync = s;
        phase_offset = off;
        phase_inc = inc;
        sample_en = 1'b1;
        tick();
        sync = 1'b0;
        sample_en = 1'b0;
        phase_offset = $urandom;
        phase_inc = $urandom;
        a = rom_addr;
        tick();
        tick();
        y = sine_out;
        v = out_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample_en = 1'($urandom);
            sync = 1'($urandom);
            phase_inc = $urandom;
            phase_offset = $urandom;
            tick();
            total_cnt++;
            if (rom_addr !== 9'd0 || sine_out !== 17'd0 || out_valid !== 1'b0)
                $display("FAIL reset_hold cyc=%0d addr=%0d sine=%h valid=%b expected 0/0/0",
                         i, rom_addr, sine_out, out_valid);
            else pass_cnt++;
        end
        reset = 1'b0;
        sample_en = 1'b0;
        sync = 1'b0;
        tick();
        total_cnt++;
        if (rom_addr !== 9'd0 || sine_out !== 17'd0 || out_valid !== 1'b0)
            $display("FAIL reset_release addr=%0d sine=%h valid=%b expected 0/0/0",
                     rom_addr, sine_out, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_step_sweep();
        logic [16:0] e;
        sync = 1'b1;
        phase_offset = 32'd0;
        sample_en = 1'b0;
        tick();
        sync = 1'b0;
        phase_inc = 32'h0020_0000;
        for (int c = 0; c < 7; c++) begin
            sample_en = (c < 4);
            tick();
            if (c < 4) begin
                total_cnt++;
                if (rom_addr !== 9'(c))
                    $display("FAIL sweep_addr cyc=%0d got %0d expected %0d", c + 1, rom_addr, c);
                else pass_cnt++;
            end
            total_cnt++;
            if (c >= 2 && c <= 5) begin
                e = 17'(1 + 64 * (c - 2));
                if (out_valid !== 1'b1 || sine_out !== e)
                    $display("FAIL sweep_out cyc=%0d valid=%b sine=%0d expected 1/%0d",
                             c + 1, out_valid, sine_out, e);
                else pass_cnt++;
            end else begin
                if (out_valid !== 1'b0)
                    $display("FAIL sweep_gap cyc=%0d valid=%b expected 0", c + 1, out_valid);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_quadrant_fold();
        logic [31:0] offs [3] = '{32'h4000_0000, 32'h8000_0000, 32'hC020_0000};
        logic [8:0]  ea   [3] = '{9'd511, 9'd0, 9'd510};
        logic signed [16:0] ey [3] = '{17'sd32705, -17'sd1, -17'sd32641};
        logic [8:0]  a;
        logic [16:0] y;
        logic        v;
        for (int i = 0; i < 3; i++) begin
            run_strobe(1'b1, offs[i], 32'h0020_0000, a, y, v);
            total_cnt++;
            if (a !== ea[i] || v !== 1'b1 || y !== ey[i])
                $display("FAIL fold off=%h addr=%0d valid=%b sine=%h expected %0d/1/%h",
                         offs[i], a, v, y, ea[i], ey[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        logic [8:0]  a;
        logic [16:0] y;
        logic        v;
        run_strobe(1'b1, 32'hFFE0_0000, 32'h0020_0000, a, y, v);
        total_cnt++;
        if (a !== 9'd0 || v !== 1'b1 || y !== 17'h1_FFFF)
            $display("FAIL wrap_first addr=%0d valid=%b sine=%h expected 0/1/1ffff", a, v, y);
        else pass_cnt++;
        run_strobe(1'b0, 32'h0, 32'h0020_0000, a, y, v);
        total_cnt++;
        if (a !== 9'd0 || v !== 1'b1 || y !== 17'd1)
            $display("FAIL wrap_second addr=%0d valid=%b sine=%h expected 0/1/1", a, v, y);
        else pass_cnt++;
        // Accumulator should now be 0x0020_0000: a zero-increment strobe reads index 1.
        run_strobe(1'b0, 32'h0, 32'h0, a, y, v);
        total_cnt++;
        if (a !== 9'd1 || v !== 1'b1 || y !== 17'd65)
            $display("FAIL wrap_acc addr=%0d valid=%b sine=%h expected 1/1/65", a, v, y);
        else pass_cnt++;
    endtask

    task automatic test_sync_sample();
        logic [8:0]  a;
        logic [16:0] y;
        logic        v;
        run_strobe(1'b1, 32'h0, 32'h0020_0000, a, y, v);
        run_strobe(1'b0, 32'h0, 32'h0020_0000, a, y, v);
        run_strobe(1'b1, 32'h8000_0000, 32'h0020_0000, a, y, v);
        total_cnt++;
        if (a !== 9'd0 || v !== 1'b1 || y !== 17'h1_FFFF)
            $display("FAIL sync_sample addr=%0d valid=%b sine=%h expected 0/1/1ffff", a, v, y);
        else pass_cnt++;
        run_strobe(1'b0, 32'h0, 32'h0020_0000, a, y, v);
        total_cnt++;
        if (a !== 9'd1 || v !== 1'b1 || $signed(y) !== -17'sd65)
            $display("FAIL sync_next addr=%0d valid=%b sine=%h expected 1/1/-65", a, v, y);
        else pass_cnt++;
    endtask

    task automatic test_sync_only();
        logic [8:0]  a;
        logic [16:0] y;
        logic        v;
        sync = 1'b1;
        phase_offset = 32'h4000_0000;
        sample_en = 1'b0;
        tick();
        sync = 1'b0;
        phase_offset = $urandom;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (out_valid !== 1'b0)
                $display("FAIL sync_only_valid cyc=%0d valid=%b expected 0", i, out_valid);
            else pass_cnt++;
        end
        run_strobe(1'b0, 32'h0, 32'h0020_0000, a, y, v);
        total_cnt++;
        if (a !== 9'd511 || v !== 1'b1 || y !== 17'd32705)
            $display("FAIL sync_only_next addr=%0d valid=%b sine=%0d expected 511/1/32705", a, v, y);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_pipeline();
        sync = 1'b1;
        phase_offset = 32'h8000_0000;
        phase_inc = 32'h0020_0000;
        sample_en = 1'b1;
        tick();
        sync = 1'b0;
        sample_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            total_cnt++;
            if (out_valid !== 1'b0 || sine_out !== 17'd0)
                $display("FAIL reset_mid cyc=t+%0d valid=%b sine=%h expected 0/0", c, out_valid, sine_out);
            else pass_cnt++;
        end
    endtask

    initial begin
        reset = 1'b1;
        sample_en = 1'b0;
        sync = 1'b0;
        phase_inc = '0;
        phase_offset = '0;
        test_reset();
        test_step_sweep();
        test_quadrant_fold();
        test_wrap();
        test_sync_sample();
        test_sync_only();
        test_reset_mid_pipeline();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/quarter_sine_phase_folder.md
# quarter_sine_phase_folder

Phase-accumulating address generator and sign restorer for the 512x16 quarter-sine ROM. It advances a phase accumulator on each sample strobe and folds the phase into a quadrant plus a table index. It drives the ROM address, then mirrors and negates the ROM magnitude into a signed full-wave sine sample. The ROM sits between this block's `rom_addr` output and `rom_q` input; the block sits directly upstream and downstream of it in the oscillator path.

## Interface
- `PHASE_WIDTH`, 32, accumulator width; wraps modulo 2^PHASE_WIDTH
- `ADDR_WIDTH`, 9, ROM address width (quarter-wave table depth 2^ADDR_WIDTH)
- `DATA_WIDTH`, 16, ROM word width (unsigned magnitude)
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `sample_en`  in  1  one-cycle strobe: emit one sample, advance phase
- `phase_inc`  in  PHASE_WIDTH  frequency word, sampled when `sample_en`=1
- `sync`  in  1  phase reset strobe: load `phase_offset` into accumulator
- `phase_offset`  in  PHASE_WIDTH  value loaded on `sync`
- `rom_addr`  out  ADDR_WIDTH  registered ROM address
- `rom_q`  in  DATA_WIDTH  ROM data, valid one cycle after `rom_addr`
- `sine_out`  out  DATA_WIDTH+1  signed two's-complement sample
- `out_valid`  out  1  one-cycle strobe qualifying `sine_out`

## Operation
- Lookup phase P: `phase_offset` if `sync`=1, otherwise the accumulator value.
- Accumulator update:
  - `sync` & `sample_en`: P + `phase_inc`.
  - `sync` only: `phase_offset`.
  - `sample_en` only: acc + `phase_inc`.
  - Neither: hold.
  - All sums truncate to PHASE_WIDTH (natural wrap).
- Fold of P:
  - Quadrant q = P[PHASE_WIDTH-1:PHASE_WIDTH-2].
  - Index idx = next ADDR_WIDTH bits below q; lower bits are ignored (no interpolation).
  - q=0: addr=idx, positive.
  - q=1: addr=2^ADDR_WIDTH-1-idx, positive.
  - q=2: addr=idx, negative.
  - q=3: addr=2^ADDR_WIDTH-1-idx, negative.
- Sign restore:
  - Magnitude m = {1'b0, `rom_q`}.
  - `sine_out` = negative ? -m : m, computed in DATA_WIDTH+1 bits; no overflow is possible.
  - Negated zero is 0.
- Pipeline:
  - Stage A (edge after `sample_en`): `rom_addr`, sign flag, valid bit.
  - Stage B: sign and valid delayed one cycle, aligned with `rom_q`.
  - Stage C: `sine_out`, `out_valid`.
  - No stalls, fully pipelined; `sample_en` may be high every cycle.
- With `sample_en`=0, `rom_addr` and `sine_out` hold their last values and `out_valid`=0.

## Timing
- Reset values:
  - Accumulator 0, `rom_addr` 0.
  - Sign and valid pipeline cleared.
  - `sine_out` 0, `out_valid` 0.
- Reset mid-operation:
  - All in-flight samples are dropped.
  - `out_valid` stays 0 until the third cycle after the first post-reset `sample_en`.
- Reset has priority over `sync` and `sample_en`.
- Latency for `sample_en` high in cycle t:
  - `rom_addr` valid in cycle t+1.
  - `rom_q` expected in cycle t+2.
  - `sine_out` valid with `out_valid`=1 in cycle t+3, for exactly one cycle per strobe.
- N consecutive strobes give N consecutive `out_valid` cycles, in order, no gaps or duplicates.
- `phase_inc` and `phase_offset` are only sampled in cycles where they are used; changing them otherwise has no effect.
- A `sync` without `sample_en` produces no output; the next strobe samples from `phase_offset`.

## Test plan
Defaults apply (32/9/16). Use a behavioural 512x16 ROM model with 1-cycle registered read and contents rom[i]=i*64+1.

- **Reset:** hold `reset` 3 cycles with random stimulus -> `rom_addr`=0, `sine_out`=0, `out_valid`=0 throughout and on the cycle after release.
- **Step sweep:** `sync` with `phase_offset`=0, then 4 back-to-back `sample_en` with `phase_inc`=0x0020_0000 -> `rom_addr`=0,1,2,3 in cycles t+1..t+4; `sine_out`=1,65,129,193 with `out_valid` high cycles t+3..t+6.
- **Quadrant fold:** single strobes at `phase_offset` (via `sync`&`sample_en`) as follows:
  - 0x4000_0000 -> addr 511, +32705.
  - 0x8000_0000 -> addr 0, -1.
  - 0xC020_0000 -> addr 510, -32641.
- **Wrap:** `phase_offset`=0xFFE0_0000, `phase_inc`=0x0020_0000, two strobes:
  - First -> addr 0, -1.
  - Second -> addr 0, +1.
  - Accumulator reads 0x0020_0000 after the second strobe.
- **Simultaneous sync/sample:** mid-sweep assert `sync`&`sample_en` with `phase_offset`=0x8000_0000, `phase_inc`=0x0020_0000 -> that sample is addr 0 / -1, and the next strobe gives addr 1 / -65.
- **Reset mid-pipeline:** `sample_en` in cycle t, `reset` in cycle t+1 -> no `out_valid` in cycles t+3..t+5, and `sine_out`=0.
